rst_seq: RTL and testbench

- Per-domain reset sequencer; one instance per generated clock domain (cpu, pxl).
- Consumes the clock generator's asynchronous ready/lock indication and an asynchronous external reset button.
- Produces a synchronous active-high domain reset, held until lock has been stable and a minimum hold time has elapsed.
- Reports loss of lock while running.

---
 rtl/rst_seq.sv | 166 ++++++++++++++++
 tb/tb_rst_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rst_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rst_seq
//  Description : Per-domain reset sequencer. Holds the domain in reset until
//                clock lock is stable and a hold time has elapsed, debounces
//                an external reset button and flags loss of lock while running.
//  Revision    : 1.0 - initial release
// ============================================================================
module rst_seq #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES        = 16,
    parameter int DEBOUNCE_CYCLES    = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ready_async_i,
    input  logic btn_async_i,
    output logic rst_o,
    output logic ready_o,
    output logic lock_lost_o
);

    localparam int c_LS_W  = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int c_H_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int c_CNT_W = (c_LS_W > c_H_W) ? c_LS_W : c_H_W;
    localparam int c_DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [c_CNT_W-1:0] c_LS_TERM   = c_CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_TERM = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_DB_W-1:0]  c_DB_TERM   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DB_W-1:0]  c_DB_ONE    = c_DB_W'(1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_STABLE    = 2'd1,
        S_HOLD      = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_lock_sync;
    logic [SYNC_STAGES-1:0] r_btn_sync;
    logic                   w_lock_s;
    logic                   w_btn_s;

    logic [c_DB_W-1:0]      r_db_cnt;
    logic                   r_btn_db;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic                   w_lock_lost_nxt;

    logic                   r_rst;
    logic                   r_ready;
    logic                   r_lock_lost;

    // Input synchronizers; bit 0 is the metastability-capture stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lock_sync <= '0;
            r_btn_sync  <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], ready_async_i};
            r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0], btn_async_i};
        end
    end

    assign w_lock_s = r_lock_sync[SYNC_STAGES-1];
    assign w_btn_s  = r_btn_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_db_cnt <= '0;
            r_btn_db <= 1'b0;
        end else if (w_btn_s != r_btn_db) begin
            if (r_db_cnt == c_DB_TERM) begin
                r_btn_db <= w_btn_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + c_DB_ONE;
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    // Lock loss outranks the button, which outranks counting.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_lock_lost_nxt = 1'b0;
        case (r_state)
            S_WAIT_LOCK: begin
                w_cnt_nxt = '0;
                if (w_lock_s) begin
                    w_state_nxt = S_STABLE;
                end
            end
            S_STABLE: begin
                if (!w_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_btn_db) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_LS_TERM) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            S_HOLD: begin
                if (!w_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_btn_db) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_HOLD_TERM) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            S_RUN: begin
                w_cnt_nxt = '0;
                if (!w_lock_s) begin
                    w_state_nxt     = S_WAIT_LOCK;
                    w_lock_lost_nxt = 1'b1;
                end else if (r_btn_db) begin
                    w_state_nxt = S_HOLD;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they switch on the same edge as the FSM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_WAIT_LOCK;
            r_cnt       <= '0;
            r_rst       <= 1'b1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rst       <= (w_state_nxt != S_RUN);
            r_ready     <= (w_state_nxt == S_RUN);
            r_lock_lost <= w_lock_lost_nxt;
        end
    end

    assign rst_o       = r_rst;
    assign ready_o     = r_ready;
    assign lock_lost_o = r_lock_lost;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rst_seq
//  Description : Directed bench for rst_seq; expected {rst,ready,lock_lost}
//                per edge are queued with the stimulus and checked each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_seq;

    localparam logic [2:0] c_RESET = 3'b100;
    localparam logic [2:0] c_RUN   = 3'b010;
    localparam logic [2:0] c_LOST  = 3'b101;
    localparam int         c_TIMEOUT_NS = 50000;

    typedef struct {
        string      tag;
        logic [2:0] exp;
    } sb_item_t;

    logic r_clk   = 1'b0;
    logic r_rst   = 1'b1;
    logic r_ready = 1'b0;
    logic r_btn   = 1'b0;
    logic w_rst_o;
    logic w_ready_o;
    logic w_lock_lost_o;

    sb_item_t r_sb[$];
    sb_item_t r_item;
    int       n_vec = 0;
    int       n_err = 0;
    logic     r_done = 1'b0;

    always #5 r_clk = ~r_clk;

    rst_seq #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .HOLD_CYCLES        (4),
        .DEBOUNCE_CYCLES    (5)
    ) u_dut (
        .clk_i         (r_clk),
        .rst_i         (r_rst),
        .ready_async_i (r_ready),
        .btn_async_i   (r_btn),
        .rst_o         (w_rst_o),
        .ready_o       (w_ready_o),
        .lock_lost_o   (w_lock_lost_o)
    );

    always @(negedge r_clk) begin
        if (r_sb.size() > 0) begin
            r_item = r_sb.pop_front();
            n_vec  = n_vec + 1;
            assert ({w_rst_o, w_ready_o, w_lock_lost_o} === r_item.exp) else begin
                n_err = n_err + 1;
                $error("FAIL %s: rst/ready/lost observed=%b expected=%b",
                       r_item.tag, {w_rst_o, w_ready_o, w_lock_lost_o}, r_item.exp);
            end
        end
    end

    initial begin
        #c_TIMEOUT_NS;
        if (!r_done) begin
            n_err = n_err + 1;
            $error("FAIL timeout: sequence did not complete within %0d ns", c_TIMEOUT_NS);
            $finish;
        end
    end

    // One queued expectation per clock edge, inputs held for those edges.
    task automatic run(input int n, input string tag, input logic [2:0] exp);
        sb_item_t it;
        for (int i = 0; i < n; i++) begin
            it.tag = tag;
            it.exp = exp;
            r_sb.push_back(it);
            @(posedge r_clk);
            #1;
        end
    endtask

    initial begin
        // Power-up: rst_o falls on the 15th edge counting the one that first samples ready.
        run(3, "reset", c_RESET);
        if ({w_rst_o, w_ready_o, w_lock_lost_o} !== c_RESET) begin
            n_err = n_err + 1;
            $error("FAIL reset_state: rst/ready/lost observed=%b expected=%b",
                   {w_rst_o, w_ready_o, w_lock_lost_o}, c_RESET);
        end
        r_rst = 1'b0;
        run(2, "wait_nolock", c_RESET);
        r_ready = 1'b1;
        run(14, "powerup_qual", c_RESET);
        run(1, "powerup_release", c_RUN);
        run(2, "powerup_run", c_RUN);

        // Lock loss in RUN, then clean requalification.
        r_ready = 1'b0;
        run(2, "loss_sync", c_RUN);
        run(1, "loss_pulse", c_LOST);
        run(2, "loss_wait", c_RESET);
        r_ready = 1'b1;
        run(14, "requal", c_RESET);
        run(1, "requal_release", c_RUN);
        run(2, "requal_run", c_RUN);

        // Short button bounce is ignored.
        r_btn = 1'b1;
        run(3, "bounce3", c_RUN);
        r_btn = 1'b0;
        run(8, "bounce3_after", c_RUN);

        // Six-cycle press is accepted and re-enters HOLD.
        r_btn = 1'b1;
        run(6, "btn6_press", c_RUN);
        r_btn = 1'b0;
        run(1, "btn6_debounce", c_RUN);
        run(9, "btn6_hold", c_RESET);
        run(1, "btn6_release", c_RUN);
        run(2, "btn6_run", c_RUN);

        // Lock drop and button acceptance land on the same FSM edge.
        r_btn = 1'b1;
        run(5, "simul_press", c_RUN);
        r_ready = 1'b0;
        run(1, "simul_drop", c_RUN);
        r_btn = 1'b0;
        run(1, "simul_sync", c_RUN);
        run(1, "simul_pulse", c_LOST);
        run(8, "simul_wait", c_RESET);
        r_ready = 1'b1;
        run(14, "simul_requal", c_RESET);
        run(1, "simul_release", c_RUN);
        run(2, "simul_run", c_RUN);

        // rst_i in RUN, then a one-cycle lock glitch at STABLE count 5.
        r_rst = 1'b1;
        run(1, "rst_in_run", c_RESET);
        r_rst = 1'b0;
        run(6, "glitch_pre", c_RESET);
        r_ready = 1'b0;
        run(1, "glitch_low", c_RESET);
        r_ready = 1'b1;
        run(14, "glitch_requal", c_RESET);
        run(1, "glitch_release", c_RUN);
        run(2, "glitch_run", c_RUN);

        // rst_i while in HOLD restarts qualification from scratch.
        r_rst = 1'b1;
        run(1, "rst_again", c_RESET);
        r_rst = 1'b0;
        run(12, "to_hold", c_RESET);
        r_rst = 1'b1;
        run(1, "rst_in_hold", c_RESET);
        r_rst = 1'b0;
        run(14, "hold_requal", c_RESET);
        run(1, "hold_release", c_RUN);
        run(3, "final_run", c_RUN);

        @(negedge r_clk);
        #1;
        if (r_sb.size() != 0) begin
            n_err = n_err + 1;
            $error("FAIL drain: %0d expectations never checked", r_sb.size());
        end
        r_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
